// File: rtl/swt16_hazard_if.sv
// swt16 hazard unit bus: decoder-side request, operand data and resolution.
// master = decoder/pipeline side, slave = hazard unit.
interface swt16_hazard_if #(
  parameter int REG_IDX_WIDTH  = 4,
  parameter int REG_WORD_WIDTH = 16,
  parameter int CNT_WIDTH      = 16
);
  logic                      in_issue;
  logic                      in_writes_reg;
  logic                      in_is_load;
  logic [REG_IDX_WIDTH-1:0]  in_dst_idx;
  logic                      in_src1_used;
  logic                      in_src2_used;
  logic [REG_IDX_WIDTH-1:0]  in_src1_idx;
  logic [REG_IDX_WIDTH-1:0]  in_src2_idx;
  logic [REG_WORD_WIDTH-1:0] in_src1_rf;
  logic [REG_WORD_WIDTH-1:0] in_src2_rf;
  logic [REG_WORD_WIDTH-1:0] in_res_EX;
  logic [REG_WORD_WIDTH-1:0] in_res_MEM;
  logic [REG_WORD_WIDTH-1:0] in_res_WB;
  logic                      in_flush;
  logic [REG_WORD_WIDTH-1:0] out_src1;
  logic [REG_WORD_WIDTH-1:0] out_src2;
  logic                      out_stall;
  logic [CNT_WIDTH-1:0]      out_stall_count;

  modport master (
    output in_issue, in_writes_reg, in_is_load, in_dst_idx,
    output in_src1_used, in_src2_used, in_src1_idx, in_src2_idx,
    output in_src1_rf, in_src2_rf, in_res_EX, in_res_MEM, in_res_WB,
    output in_flush,
    input  out_src1, out_src2, out_stall, out_stall_count
  );

  modport slave (
    input  in_issue, in_writes_reg, in_is_load, in_dst_idx,
    input  in_src1_used, in_src2_used, in_src1_idx, in_src2_idx,
    input  in_src1_rf, in_src2_rf, in_res_EX, in_res_MEM, in_res_WB,
    input  in_flush,
    output out_src1, out_src2, out_stall, out_stall_count
  );
endinterface

// File: rtl/swt16_hazard_unit.sv
// swt16 hazard unit: EX/MEM/WB destination tracking, operand forwarding,
// load-use / interlock stall generation and a saturating stall counter.
module swt16_hazard_unit #(
  parameter int REG_IDX_WIDTH  = 4,
  parameter int REG_WORD_WIDTH = 16,
  parameter int FWD_ENABLE     = 1,
  parameter int CNT_WIDTH      = 16
) (
  input logic           clock,
  input logic           reset,
  swt16_hazard_if.slave hz
);

  typedef struct packed {
    logic                     valid;
    logic                     writes;
    logic                     is_load;
    logic [REG_IDX_WIDTH-1:0] dst;
  } slot_t;

  localparam bit LP_FWD = (FWD_ENABLE != 0);

  slot_t                r_ex;
  slot_t                r_mem;
  slot_t                r_wb;
  logic [CNT_WIDTH-1:0] r_cnt;

  logic w_m1_ex, w_m1_mem, w_m1_wb;
  logic w_m2_ex, w_m2_mem, w_m2_wb;
  logic w_load_use, w_any_match, w_hazard, w_stall;
  logic [REG_WORD_WIDTH-1:0] w_src1, w_src2;

  function automatic logic f_match(
    input slot_t                    s,
    input logic                     used,
    input logic [REG_IDX_WIDTH-1:0] idx
  );
    return s.valid & s.writes & used & (s.dst == idx);
  endfunction

  assign w_m1_ex  = f_match(r_ex,  hz.in_src1_used, hz.in_src1_idx);
  assign w_m1_mem = f_match(r_mem, hz.in_src1_used, hz.in_src1_idx);
  assign w_m1_wb  = f_match(r_wb,  hz.in_src1_used, hz.in_src1_idx);
  assign w_m2_ex  = f_match(r_ex,  hz.in_src2_used, hz.in_src2_idx);
  assign w_m2_mem = f_match(r_mem, hz.in_src2_used, hz.in_src2_idx);
  assign w_m2_wb  = f_match(r_wb,  hz.in_src2_used, hz.in_src2_idx);

  assign w_load_use  = (w_m1_ex | w_m2_ex) & r_ex.is_load;
  assign w_any_match = w_m1_ex | w_m1_mem | w_m1_wb
                     | w_m2_ex | w_m2_mem | w_m2_wb;
  assign w_hazard    = LP_FWD ? w_load_use : w_any_match;
  // A flush squashes the instruction in DC, so it never needs to wait.
  assign w_stall     = w_hazard & hz.in_issue & ~hz.in_flush;

  // Operand select: youngest producer wins; without forwarding use the RF.
  always_comb begin
    w_src1 = hz.in_src1_rf;
    w_src2 = hz.in_src2_rf;
    if (LP_FWD) begin
      if (w_m1_ex)       w_src1 = hz.in_res_EX;
      else if (w_m1_mem) w_src1 = hz.in_res_MEM;
      else if (w_m1_wb)  w_src1 = hz.in_res_WB;
      if (w_m2_ex)       w_src2 = hz.in_res_EX;
      else if (w_m2_mem) w_src2 = hz.in_res_MEM;
      else if (w_m2_wb)  w_src2 = hz.in_res_WB;
    end
  end

  assign hz.out_src1        = w_src1;
  assign hz.out_src2        = w_src2;
  assign hz.out_stall       = w_stall;
  assign hz.out_stall_count = r_cnt;

  // Shift the tracking slots; a stalled or flushed issue becomes a bubble.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_wb  <= '0;
    end else begin
      r_wb  <= r_mem;
      r_mem <= r_ex;
      if (hz.in_issue & ~w_stall & ~hz.in_flush)
        r_ex <= {1'b1, hz.in_writes_reg, hz.in_is_load, hz.in_dst_idx};
      else
        r_ex <= '0;
    end
  end

  // Saturating stall-cycle counter for profiling.
  always_ff @(posedge clock) begin
    if (reset)
      r_cnt <= '0;
    else if (w_stall && (r_cnt != '1))
      r_cnt <= r_cnt + CNT_WIDTH'(1);
  end

endmodule

// File: doc/swt16_hazard_unit.md
# swt16_hazard_unit

Parametrised hazard unit for the swt16 five-stage pipeline. It tracks the destination register of each instruction in flight in EX, MEM and WB, and forwards results to the decoder's source operands. It raises a stall when an operand cannot be forwarded yet. It sits between the decoder and the register file outputs and replaces the direct regfile-to-decoder operand path. A forwarding-disable mode gives a pure-interlock fallback, and a saturating counter reports stall cycles for profiling.

## Interface
- REG_IDX_WIDTH, 4: register index width.
- REG_WORD_WIDTH, 16: operand/result width.
- FWD_ENABLE, 1: 1 = forward plus load-use interlock; 0 = interlock only, no forwarding.
- CNT_WIDTH, 16: stall counter width.
- clock  in  1  single clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- in_issue  in  1  decoder presents a valid instruction in DC this cycle.
- in_writes_reg  in  1  issued instruction writes a register.
- in_is_load  in  1  issued instruction is a DMEM load.
- in_dst_idx  in  REG_IDX_WIDTH  destination index of the issued instruction.
- in_src1_used, in_src2_used  in  1 each  operand is read.
- in_src1_idx, in_src2_idx  in  REG_IDX_WIDTH each  source indices.
- in_src1_rf, in_src2_rf  in  REG_WORD_WIDTH each  register file read data.
- in_res_EX  in  REG_WORD_WIDTH  combinational ALU result of the instruction in EX.
- in_res_MEM  in  REG_WORD_WIDTH  result leaving MEM, including load data.
- in_res_WB  in  REG_WORD_WIDTH  value being written to the register file this cycle.
- in_flush  in  1  pipeline flush from EX (taken jump).
- out_src1, out_src2  out  REG_WORD_WIDTH each  resolved operands to the DC/EX register.
- out_stall  out  1  hold IF/DC and insert a bubble into EX.
- out_stall_count  out  CNT_WIDTH  saturating count of stall cycles.

## Operation
- Three tracking slots: EX, MEM, WB. Each slot holds {valid, writes, is_load, dst_idx}.
- A slot matches operand n when: slot valid, slot writes, slot dst_idx == in_srcn_idx, and in_srcn_used.
- There is no hardwired-zero register. Index 0 is tracked like any other register.
- Forwarding, FWD_ENABLE=1:
  - out_srcn selects the youngest match, in priority EX (in_res_EX), then MEM (in_res_MEM), then WB (in_res_WB).
  - With no match, out_srcn = in_srcn_rf.
- Load-use rule: if the EX slot matches and has is_load=1, out_stall=1 for that operand. Load data first appears on in_res_MEM one cycle later.
- Interlock, FWD_ENABLE=0:
  - out_srcn always equals in_srcn_rf.
  - out_stall=1 while any slot matches either operand.
- Register file has no write-through, so a WB match must stall in this mode.
- Stall gating: out_stall is only asserted when in_issue=1 and in_flush=0.
- Slot update each cycle, in order:
  - WB <= MEM, MEM <= EX.
  - EX <= {in_issue, in_writes_reg, in_is_load, in_dst_idx} when in_issue=1, out_stall=0 and in_flush=0.
  - Otherwise EX <= invalid (bubble).
- Flush: in_flush=1 forces the EX slot invalid next cycle. MEM and WB shift normally, so the jump itself retires.
- Stall counter: increments by 1 on each cycle with out_stall=1. It holds at all-ones and never wraps.

## Timing
- out_src1, out_src2 and out_stall are combinational from slot state and the current inputs. No added latency on the operand path.
- Slot shift and counter update are registered, one cycle.
- Load-use with forwarding costs exactly 1 stall cycle. The next cycle forwards from MEM.
- Interlock mode stalls for at most 3 cycles per dependency: the producer in EX → 3, in MEM → 2, in WB → 1.
- On reset (synchronous, high at rising edge):
  - All slots invalid.
  - out_stall_count=0.
  - Therefore out_stall=0 and out_srcn=in_srcn_rf from the first cycle after reset.
- Reset mid-stall clears the slots and the counter on the same edge. No stall persists afterwards.
- Simultaneous in_flush and stall condition: flush wins, out_stall=0, EX becomes a bubble, counter does not increment.

## Test plan
- Back-to-back ADD r3 → ADD using r3, FWD_ENABLE=1, in_res_EX=0x1234: out_src1=0x1234, out_stall=0.
- Same register written in EX (0xAAAA), MEM (0xBBBB) and WB (0xCCCC): out_src1=0xAAAA. Stall EX so that it becomes a bubble: next cycle out_src1=0xBBBB.
- LOAD r5 then consumer of r5 (FWD_ENABLE=1):
  - Cycle 1: out_stall=1, counter 0→1.
  - Cycle 2: out_stall=0, out_src1=in_res_MEM=0x00FF.
- FWD_ENABLE=0, ADD r2 then consumer of r2: out_stall=1 for 3 cycles, then out_src1=in_src1_rf, counter=3.
- Load-use stall with in_flush=1 in the same cycle: out_stall=0, counter unchanged, EX slot invalid next cycle.
- Counter with CNT_WIDTH=4, 20 consecutive stall cycles: out_stall_count=15. Then reset → 0 and all slots invalid.
